// File: rtl/ram_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_bus_pkg : shared defaults and FSM encoding for the RAM bus master |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package ram_bus_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_RSP  = 3'd3,
    ST_VFY  = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ram_bus_tri.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_bus_tri : tristate driver for the shared RAM data bus            |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module ram_bus_tri #(
  parameter int DATA_W = 32
) (
  input  logic              drive_en,
  input  logic [DATA_W-1:0] drive_val,
  inout  wire  [DATA_W-1:0] bus
);

  assign bus = drive_en ? drive_val : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: rtl/ram_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_bus_master : burst read/write master for a tristate-bus RAM      |
// | Optional write-verify cycle enabled by RAM_BUS_VERIFY_EN             |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module ram_bus_master
  import ram_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              ram_ena,
  output logic              ram_wena,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              drive_en;

`ifdef RAM_BUS_VERIFY_EN
  logic [DATA_W-1:0] wbuf_q, wbuf_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
    end
  end

`ifdef RAM_BUS_VERIFY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbuf_q     <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      wbuf_q     <= wbuf_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    rd_data_d   = rd_data_q;
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    rd_valid    = 1'b0;
    ram_ena     = 1'b0;
    ram_wena    = 1'b0;
    ram_addr    = '0;
    busy        = 1'b1;
`ifdef RAM_BUS_VERIFY_EN
    wbuf_d      = wbuf_q;
    err_d       = err_q;
    err_addr_d  = err_addr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        busy      = 1'b0;
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          cnt_d   = req_len;
          state_d = req_write ? ST_WR : ST_RD;
        end
      end

      ST_WR: begin
        wdata_ready = 1'b1;
        ram_ena     = wdata_valid;
        ram_wena    = wdata_valid;
        ram_addr    = addr_q;
        if (wdata_valid) begin
`ifdef RAM_BUS_VERIFY_EN
          // Address advances only after the verify read of this beat.
          wbuf_d  = wdata;
          state_d = ST_VFY;
`else
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            addr_d = addr_q + c_addr_one;
            cnt_d  = cnt_q - c_addr_one;
          end
`endif
        end
      end

      ST_RD: begin
        ram_ena   = 1'b1;
        ram_addr  = addr_q;
        rd_data_d = ram_data;
        state_d   = ST_RSP;
      end

      ST_RSP: begin
        rd_valid = 1'b1;
        if (rd_ready) begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            addr_d  = addr_q + c_addr_one;
            cnt_d   = cnt_q - c_addr_one;
            state_d = ST_RD;
          end
        end
      end

`ifdef RAM_BUS_VERIFY_EN
      ST_VFY: begin
        ram_ena  = 1'b1;
        ram_addr = addr_q;
        if (ram_data != wbuf_q) begin
          err_d = 1'b1;
          if (!err_q) begin
            err_addr_d = addr_q;
          end
        end
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          addr_d  = addr_q + c_addr_one;
          cnt_d   = cnt_q - c_addr_one;
          state_d = ST_WR;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  assign drive_en = ram_ena & ram_wena;
  assign rd_data  = rd_data_q;

`ifdef RAM_BUS_VERIFY_EN
  assign err      = err_q;
  assign err_addr = err_addr_q;
`else
  assign err      = 1'b0;
  assign err_addr = '0;
`endif

  ram_bus_tri #(
    .DATA_W (DATA_W)
  ) u_tri (
    .drive_en  (drive_en),
    .drive_val (wdata),
    .bus       (ram_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_ram_bus_master.sv
`default_nettype none
// Directed self-checking bench for ram_bus_master with a behavioural tristate RAM.
module tb_ram_bus_master;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam logic [DW-1:0] IDLE_PAT = 32'hCAFE_F00D;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [AW-1:0] req_len = '0;
  logic          wdata_valid = 1'b0;
  logic          wdata_ready;
  logic [DW-1:0] wdata = IDLE_PAT;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          ram_ena;
  logic          ram_wena;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;
  logic          err;
  logic [AW-1:0] err_addr;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] beat_data [8];
  logic [AW-1:0] wr_addr_log [8];

  always #5 clk = ~clk;

  ram_bus_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr),
    .ram_data(ram_data), .err(err), .err_addr(err_addr)
  );

  // RAM model: asynchronous read onto the bus, write on the clock edge.
  logic [DW-1:0] mem [32];
  logic          mem_load = 1'b1;
  logic          corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;
  logic [DW-1:0] ram_rd_word;

  always_comb begin
    ram_rd_word = mem[ram_addr];
    if (corrupt_en && ram_addr == corrupt_addr) ram_rd_word = mem[ram_addr] ^ 32'h1;
  end

  assign ram_data = (ram_ena && !ram_wena) ? ram_rd_word : {DW{1'bz}};

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 + i;
    end else if (ram_ena && ram_wena) begin
      mem[ram_addr] <= ram_data;
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Nothing but the RAM may drive the bus while it is disabled; wdata is never 0.
  always @(negedge clk) begin
    #2;
    if (ram_ena !== 1'b1) check("bus_released", DW'((|ram_data) === 1'b1), DW'(0));
  end

  task automatic write_burst(input logic [AW-1:0] a, input int len);
    logic [AW-1:0] ea;
    ea = a;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_len = AW'(len);
    #1 check("wr_req_ready", DW'(req_ready), DW'(1));
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wdata_valid = 1'b1; wdata = beat_data[i];
      #1;
      check("wr_wdata_ready", DW'(wdata_ready), DW'(1));
      check("wr_ena_wena", DW'({ram_ena, ram_wena}), DW'(2'b11));
      check("wr_addr", DW'(ram_addr), DW'(ea));
      wr_addr_log[i] = ram_addr;
      @(negedge clk);
      wdata_valid = 1'b0; wdata = IDLE_PAT;
`ifdef RAM_BUS_VERIFY_EN
      #1;
      check("vfy_ena_wena_wrdy", DW'({ram_ena, ram_wena, wdata_ready}), DW'(3'b100));
      check("vfy_addr", DW'(ram_addr), DW'(ea));
      @(negedge clk);
`endif
      ea = ea + AW'(1);
    end
    #1;
    check("wr_done_busy", DW'(busy), DW'(0));
    check("wr_done_wena", DW'(ram_wena), DW'(0));
  endtask

  task automatic read_burst(input logic [AW-1:0] a, input int len, input int stall);
    logic [AW-1:0] ea;
    ea = a;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = AW'(len);
    #1 check("rd_req_ready", DW'(req_ready), DW'(1));
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      #1;
      check("rd_phase_flags", DW'({rd_valid, ram_ena, ram_wena, req_ready}), DW'(4'b0100));
      check("rd_addr", DW'(ram_addr), DW'(ea));
      @(negedge clk);
      #1;
      check("rsp_valid", DW'(rd_valid), DW'(1));
      check("rsp_data", rd_data, beat_data[i]);
      if (i == 0 && stall > 0) begin
        // A write request offered while busy must be ignored.
        req_valid = 1'b1; req_write = 1'b1;
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          #1;
          check("stall_flags", DW'({rd_valid, ram_ena, req_ready}), DW'(3'b100));
          check("stall_data", rd_data, beat_data[i]);
        end
        req_valid = 1'b0;
      end
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
      ea = ea + AW'(1);
    end
    #1 check("rd_done_busy", DW'(busy), DW'(0));
  endtask

  initial begin
    #1_000_000;
    check("watchdog", DW'(1), DW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_ram_ena", DW'({ram_ena, ram_wena}), DW'(0));
    check("rst_ram_addr", DW'(ram_addr), DW'(0));
    check("rst_rd", DW'({rd_valid, wdata_ready, err}), DW'(0));
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_err_addr", DW'(err_addr), DW'(0));
    rst_n = 1'b1; mem_load = 1'b0;
    #1 check("post_rst_req_ready", DW'(req_ready), DW'(1));

    // Single-beat write then read of address 5.
    beat_data[0] = 32'hDEAD_BEEF;
    write_burst(5'd5, 0);
    read_burst(5'd5, 0, 0);

    // Wrapping 4-beat burst at 30.
    beat_data[0] = 32'd1; beat_data[1] = 32'd2; beat_data[2] = 32'd3; beat_data[3] = 32'd4;
    write_burst(5'd30, 3);
    check("wrap_addr0", DW'(wr_addr_log[0]), DW'(30));
    check("wrap_addr1", DW'(wr_addr_log[1]), DW'(31));
    check("wrap_addr2", DW'(wr_addr_log[2]), DW'(0));
    check("wrap_addr3", DW'(wr_addr_log[3]), DW'(1));
    read_burst(5'd30, 3, 0);

    // 2-beat read with a 5-cycle stall: addresses 0,1 hold 3,4 after the wrap.
    beat_data[0] = 32'd3; beat_data[1] = 32'd4;
    read_burst(5'd0, 1, 5);

    // Reset during the second beat of a 4-beat write at 12.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd12; req_len = 5'd3;
    @(negedge clk);
    req_valid = 1'b0;
    wdata_valid = 1'b1; wdata = 32'h1111_0001;
    @(negedge clk);
    wdata_valid = 1'b0; wdata = IDLE_PAT;
`ifdef RAM_BUS_VERIFY_EN
    @(negedge clk);
`endif
    wdata_valid = 1'b1; wdata = 32'h1111_0002;
    #1 check("beat2_active", DW'({ram_ena, ram_wena}), DW'(2'b11));
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ena", DW'({ram_ena, ram_wena, wdata_ready}), DW'(0));
    check("midrst_addr", DW'(ram_addr), DW'(0));
    check("midrst_bus", DW'((|ram_data) === 1'b1), DW'(0));
    check("midrst_rd_data", rd_data, 32'h0);
    @(negedge clk);
    wdata_valid = 1'b0; wdata = IDLE_PAT; rst_n = 1'b1;
    #1 check("rel_req_ready", DW'({req_ready, busy}), DW'(2'b10));
    @(negedge clk);
    #1 check("no_resume", DW'({busy, ram_ena}), DW'(0));
    beat_data[0] = 32'h1111_0001; beat_data[1] = 32'h1000_000D;
    read_burst(5'd12, 1, 0);

`ifdef RAM_BUS_VERIFY_EN
    corrupt_en = 1'b1; corrupt_addr = 5'd9;
    beat_data[0] = 32'hA; beat_data[1] = 32'hB; beat_data[2] = 32'hC;
    write_burst(5'd8, 2);
    check("vfy_err", DW'(err), DW'(1));
    check("vfy_err_addr", DW'(err_addr), DW'(9));
    beat_data[0] = 32'h55;
    write_burst(5'd3, 0);
    check("vfy_err_sticky", DW'(err), DW'(1));
    corrupt_addr = 5'd20;
    beat_data[0] = 32'h66;
    write_burst(5'd20, 0);
    check("vfy_err_addr_first", DW'(err_addr), DW'(9));
`else
    corrupt_en = 1'b1; corrupt_addr = 5'd9;
    beat_data[0] = 32'hA;
    write_burst(5'd9, 0);
    repeat (2) @(negedge clk);
    #1 check("no_vfy_err", DW'({err, err_addr}), DW'(0));
`endif
    corrupt_en = 1'b0;

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_bus_master.md
RAM_BUS_MASTER -- requirements
Module: ram_bus_master

Interface
REQ-001 Parameter ADDR_W, default 5, RAM address width; depth is 2^ADDR_W words.
REQ-002 Parameter DATA_W, default 32, RAM word width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  request offered by the client.
REQ-006 req_ready  output  1  request accepted when high with req_valid.
REQ-007 req_write  input  1  1 = burst write, 0 = burst read.
REQ-008 req_addr  input  ADDR_W  burst start address.
REQ-009 req_len  input  ADDR_W  beats minus one; 0..31 gives 1..32 beats.
REQ-010 wdata_valid / wdata_ready  input / output  1 / 1  write-data stream handshake.
REQ-011 wdata  input  DATA_W  write beat payload.
REQ-012 rd_valid / rd_ready  output / input  1 / 1  read-data stream handshake.
REQ-013 rd_data  output  DATA_W  read beat payload.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 ram_ena, ram_wena  output  1, 1  RAM enable and write-enable.
REQ-016 ram_addr  output  ADDR_W  RAM address.
REQ-017 ram_data  inout  DATA_W  shared tristate RAM data bus.
REQ-018 err  output  1  sticky verify mismatch; tied 0 without RAM_BUS_VERIFY_EN.
REQ-019 err_addr  output  ADDR_W  address of the first mismatch; tied 0 without RAM_BUS_VERIFY_EN.

Function
REQ-020 The FSM SHALL have states IDLE, WR, RD, RSP and, with the macro, VFY.
REQ-021 IDLE: req_ready=1, ram_ena=0; on req_valid, latch addr/len/write and go to WR (write) or RD (read) on the next edge.
REQ-022 req_ready SHALL be 0 outside IDLE; requests offered while busy are not accepted.
REQ-023 WR: wdata_ready=1; ram_ena=ram_wena=wdata_valid (combinational); ram_data driven with wdata only while wdata_valid; the RAM commits the word at that edge.
REQ-024 WR beat rules: each accepted beat increments the address modulo 2^ADDR_W (31 wraps to 0) and decrements the count; the last beat returns to IDLE.
REQ-025 The master SHALL drive ram_data only when ram_ena=1 and ram_wena=1, and SHALL drive Z at all other times.
REQ-026 RD: ram_ena=1, ram_wena=0, bus released; ram_data is sampled into rd_data at the edge; go to RSP.
REQ-027 RSP: rd_valid=1 and rd_data stable until rd_ready; on handshake, go to IDLE after the last beat, otherwise increment the address (wrapping) and go to RD.
REQ-028 Read throughput SHALL be at most one beat per 2 cycles; rd_valid first rises 2 cycles after request acceptance.
REQ-029 ram_addr SHALL equal the current burst address in WR, RD and VFY, and 0 in IDLE.

Reset
REQ-030 Asserting rst_n low SHALL immediately force the following, including mid-burst: state IDLE; ram_ena=0, ram_wena=0, ram_addr=0, ram_data=Z; rd_valid=0, rd_data=0; wdata_ready=0; err=0, err_addr=0.
REQ-031 After reset deasserts, req_ready=1 on the first cycle and no partial burst resumes.

Configuration
REQ-032 With RAM_BUS_VERIFY_EN defined, each write beat SHALL be followed by a VFY cycle that reads the same address with ram_wena=0 and compares it against the saved beat.
REQ-033 On mismatch, err SHALL set (sticky until reset), and err_addr SHALL capture the address only if err was previously 0.
REQ-034 VFY SHALL then return to WR, or to IDLE after the last beat; wdata_ready=0 in VFY.
REQ-035 Without RAM_BUS_VERIFY_EN, VFY SHALL be absent, writes SHALL sustain one beat per cycle, and err and err_addr SHALL be constant 0.

Structure
REQ-036 Shared package ram_bus_pkg SHALL hold the state encoding constants and ADDR_W/DATA_W defaults.
REQ-037 The tristate driver SHALL be sub-module ram_bus_tri (inputs: drive enable and value; inout: bus); all other logic stays in ram_bus_master.

Verification
REQ-038 Write addr 5, len 0, 0xDEADBEEF, then read addr 5 -> ram_wena pulses for 1 cycle; rd_data=0xDEADBEEF with rd_valid 2 cycles after acceptance.
REQ-039 Write addr 30, len 3, data 1,2,3,4 -> ram_addr sequence 30,31,0,1; reading back addr 30, len 3 returns 1,2,3,4.
REQ-040 Read a 2-beat burst with rd_ready held low for 5 cycles -> rd_data stable and ram_ena=0 during the stall; second beat follows the handshake.
REQ-041 Assert rst_n low during beat 2 of a 4-beat write -> ram_ena=0 and ram_data=Z in the same cycle; req_ready=1 after release.
REQ-042 Bus contention check over all tests -> the master never drives ram_data while ram_wena=0.
REQ-043 With RAM_BUS_VERIFY_EN, the RAM model corrupts addr 9 -> err=1, err_addr=9; a later good burst leaves err=1.
